// File: rtl/vape_er_atomic_monitor.sv
// Atomicity monitor for an executable region (ER): tracks entry at ER_min, exit via ER_max.
// Optional macro VAPE_IRQ_CHECK_EN: an interrupt taken mid-run aborts the execution.
module vape_er_atomic_monitor #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    output logic        exec_ok,
    output logic        in_run,
    output logic        violation,
    output logic [7:0]  abort_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_e;

    state_e      state_q, state_d;
    logic [15:0] prev_pc_q, prev_pc_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;
    logic        exec_ok_q, exec_ok_d;
    logic        in_run_q, in_run_d;
    logic        violation_q, violation_d;

    logic pc_in_er, pc_at_min, er_empty, irq_abort;

    assign pc_in_er  = (pc >= ER_min) && (pc <= ER_max);
    assign pc_at_min = (pc == ER_min);
    assign er_empty  = (ER_min > ER_max);

`ifdef VAPE_IRQ_CHECK_EN
    assign irq_abort = irq;
`else
    logic unused_irq;
    assign irq_abort  = 1'b0;
    assign unused_irq = irq;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_pc_q   <= 16'h0000;
            abort_cnt_q <= 8'h00;
            exec_ok_q   <= 1'b0;
            in_run_q    <= 1'b0;
            violation_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_pc_q   <= prev_pc_d;
            abort_cnt_q <= abort_cnt_d;
            exec_ok_q   <= exec_ok_d;
            in_run_q    <= in_run_d;
            violation_q <= violation_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (pc_at_min)     state_d = RUN;
                else if (pc_in_er) state_d = ABORT;
            end
            RUN: begin
                if (irq_abort)      state_d = ABORT;
                else if (!pc_in_er) state_d = (prev_pc_q == ER_max) ? DONE : ABORT;
            end
            ABORT: begin
                if (pc_at_min)                  state_d = RUN;
                else if (pc == RESET_HANDLER)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An inverted region cannot be executed legally or illegally.
        if (er_empty) state_d = IDLE;
    end

    // output logic: flags are registered decodes of the next state
    always_comb begin
        prev_pc_d   = pc;
        exec_ok_d   = (state_d == DONE);
        in_run_d    = (state_d == RUN);
        violation_d = (state_d == ABORT);
        abort_cnt_d = abort_cnt_q;
        if ((state_d == ABORT) && (state_q != ABORT) && (abort_cnt_q != 8'hFF))
            abort_cnt_d = abort_cnt_q + 8'd1;
    end

    assign exec_ok   = exec_ok_q;
    assign in_run    = in_run_q;
    assign violation = violation_q;
    assign abort_cnt = abort_cnt_q;

endmodule
